// File: rtl/op_window_gen.sv
// ---------------------------------------------------------------------------
// op_window_gen
// Producer side of the 5x5 window interface used by the neighbourhood
// operators. A raster pixel stream is swept over a padded
// (IMG_WIDTH+4) x (IMG_HEIGHT+4) grid. Each grid step shifts one source pixel
// (the accepted pixel inside the image, zero in the pad region) into a 5x5
// register window. Four chained line buffers supply the older rows.
//
// Ports
//   clock       in   clock, all state on the rising edge
//   reset       in   synchronous, active-high reset
//   in_valid    in   in_data holds a valid pixel
//   in_ready    out  pixel accepted when in_valid && in_ready (combinational)
//   in_data     in   raster-order pixel, row-major, top-left first
//   out_valid   out  one-cycle pulse per grid step
//   window      out  5x5 window, byte (r*5+c) = grid pixel (y-r, x-c)
//   x, y        out  grid coordinates of the newest tap
//   frame_done  out  pulse together with the final step (W+3, H+3)
// ---------------------------------------------------------------------------
module op_window_gen #(
    parameter int DWIDTH     = 8,
    parameter int DWIDTH_OUT = DWIDTH * 25,
    parameter int IMG_WIDTH  = 64,
    parameter int IMG_HEIGHT = 48
) (
    input  logic                                  clock,
    input  logic                                  reset,
    input  logic                                  in_valid,
    output logic                                  in_ready,
    input  logic [DWIDTH-1:0]                     in_data,
    output logic                                  out_valid,
    output logic [DWIDTH_OUT-1:0]                 window,
    output logic [$clog2(IMG_WIDTH+5)-1:0]        x,
    output logic [$clog2(IMG_HEIGHT+5)-1:0]       y,
    output logic                                  frame_done
);

    localparam int XW       = $clog2(IMG_WIDTH + 5);
    localparam int YW       = $clog2(IMG_HEIGHT + 5);
    localparam int LB_DEPTH = IMG_WIDTH + 4;
    localparam int AW       = $clog2(LB_DEPTH);

    localparam logic [XW-1:0] X_IMG      = XW'(IMG_WIDTH);
    localparam logic [XW-1:0] X_LAST     = XW'(IMG_WIDTH + 3);
    localparam logic [YW-1:0] Y_IMG      = YW'(IMG_HEIGHT);
    localparam logic [YW-1:0] Y_LAST_IMG = YW'(IMG_HEIGHT - 1);
    localparam logic [YW-1:0] Y_LAST     = YW'(IMG_HEIGHT + 3);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_FLUSH = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_state_next;
    logic [XW-1:0]         r_gx;
    logic [XW-1:0]         w_gx_next;
    logic [YW-1:0]         r_gy;
    logic [YW-1:0]         w_gy_next;
    logic                  w_in_image;
    logic                  w_ready;
    logic                  w_step;
    logic                  w_row_end;
    logic                  w_frame_end;
    logic [AW-1:0]         w_addr;
    logic [DWIDTH-1:0]     w_pix;
    logic [DWIDTH-1:0]     w_tap [0:3];
    logic [DWIDTH_OUT-1:0] w_window_next;

    // Line buffers are never cleared; stale contents only reach taps above row 0.
    logic [DWIDTH-1:0]     r_lb [0:3][0:LB_DEPTH-1];

    logic                  r_out_valid;
    logic [DWIDTH_OUT-1:0] r_window;
    logic [XW-1:0]         r_x;
    logic [YW-1:0]         r_y;
    logic                  r_frame_done;

    // Step decode: acceptance, pad stepping and source pixel selection.
    always_comb begin
        w_in_image  = (r_gx < X_IMG) && (r_gy < Y_IMG);
        w_row_end   = (r_gx == X_LAST);
        w_frame_end = w_row_end && (r_gy == Y_LAST);
        w_addr      = r_gx[AW-1:0];
        w_ready     = 1'b0;
        w_step      = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_ready = (r_gx < X_IMG);
                w_step  = in_valid && w_ready;
            end
            S_RUN: begin
                w_ready = (r_gx < X_IMG);
                // Pad columns advance every cycle without waiting for input.
                w_step  = w_ready ? in_valid : 1'b1;
            end
            S_FLUSH: begin
                w_ready = 1'b0;
                w_step  = 1'b1;
            end
            default: begin
                w_ready = 1'b0;
                w_step  = 1'b0;
            end
        endcase
        if (w_in_image) begin
            w_pix = in_data;
        end else begin
            w_pix = {DWIDTH{1'b0}};
        end
    end

    assign in_ready = w_ready;

    // Next-state and grid counter logic.
    always_comb begin
        w_state_next = r_state;
        w_gx_next    = r_gx;
        w_gy_next    = r_gy;
        if (w_step) begin
            if (w_row_end) begin
                w_gx_next = {XW{1'b0}};
                if (r_gy == Y_LAST) begin
                    w_gy_next = {YW{1'b0}};
                end else begin
                    w_gy_next = r_gy + {{(YW-1){1'b0}}, 1'b1};
                end
            end else begin
                w_gx_next = r_gx + {{(XW-1){1'b0}}, 1'b1};
                w_gy_next = r_gy;
            end
        end else begin
            w_gx_next = r_gx;
            w_gy_next = r_gy;
        end
        case (r_state)
            S_IDLE: begin
                if (w_step) begin
                    w_state_next = S_RUN;
                end else begin
                    w_state_next = S_IDLE;
                end
            end
            S_RUN: begin
                if (w_step && w_row_end && (r_gy == Y_LAST_IMG)) begin
                    w_state_next = S_FLUSH;
                end else begin
                    w_state_next = S_RUN;
                end
            end
            S_FLUSH: begin
                if (w_step && w_frame_end) begin
                    w_state_next = S_IDLE;
                end else begin
                    w_state_next = S_FLUSH;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Line-buffer taps: entry at column gx was written exactly W+4 steps ago.
    always_comb begin
        for (int k = 0; k < 4; k++) begin
            w_tap[k] = r_lb[k][w_addr];
        end
    end

    // Window shift: every row moves one column right, column 0 takes new data.
    always_comb begin
        w_window_next = r_window;
        w_window_next[0 +: DWIDTH] = w_pix;
        for (int r = 1; r < 5; r++) begin
            w_window_next[DWIDTH*(r*5) +: DWIDTH] = w_tap[r-1];
        end
        for (int r = 0; r < 5; r++) begin
            for (int c = 1; c < 5; c++) begin
                w_window_next[DWIDTH*(r*5+c) +: DWIDTH] = r_window[DWIDTH*(r*5+c-1) +: DWIDTH];
            end
        end
    end

    // Chained delay lines, advanced only on grid steps.
    always_ff @(posedge clock) begin
        if (w_step) begin
            r_lb[0][w_addr] <= w_pix;
            for (int k = 1; k < 4; k++) begin
                r_lb[k][w_addr] <= w_tap[k-1];
            end
        end
    end

    // FSM state and grid counter registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_gx    <= {XW{1'b0}};
            r_gy    <= {YW{1'b0}};
        end else begin
            r_state <= w_state_next;
            r_gx    <= w_gx_next;
            r_gy    <= w_gy_next;
        end
    end

    // Output registers: one-cycle latency from a step; hold when no step.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_out_valid  <= 1'b0;
            r_frame_done <= 1'b0;
            r_window     <= {DWIDTH_OUT{1'b0}};
            r_x          <= {XW{1'b0}};
            r_y          <= {YW{1'b0}};
        end else begin
            r_out_valid  <= w_step;
            r_frame_done <= w_step && w_frame_end;
            if (w_step) begin
                r_window <= w_window_next;
                r_x      <= r_gx;
                r_y      <= r_gy;
            end
        end
    end

    assign out_valid  = r_out_valid;
    assign frame_done = r_frame_done;
    assign window     = r_window;
    assign x          = r_x;
    assign y          = r_y;

endmodule
